// File: rtl/spi_reg_bank.sv
// Command decoder and register bank running in the SPI clock domain.
// The first byte of each chip-select frame is a command: bit7 selects read or write,
// the low ADDR_W bits give the start address, and the bits in between must be zero.
// The bytes that follow it in the same frame are written into the bank, or the bank
// supplies the next byte to shift out on MISO. The address auto-increments with wrap.
module spi_reg_bank #(
    parameter int                       ADDR_W  = 4,
    parameter logic [(2**ADDR_W)-1:0]   RO_MASK = '0
) (
    input  logic                         w_SPI_Clk,
    input  logic                         i_Rst_L,
    input  logic                         i_SPI_CS_n,
    input  logic                         i_Byte_DV,
    input  logic [7:0]                   i_Byte,
    input  logic [7:0]                   i_Status,
    output logic                         o_TX_Load,
    output logic [7:0]                   o_TX_Byte,
    output logic                         o_Wr_Strobe,
    output logic [ADDR_W-1:0]            o_Wr_Addr,
    output logic [7:0]                   o_Wr_Data,
    output logic [8*(2**ADDR_W)-1:0]     o_Regs,
    output logic                         o_Frame_Err
);

    localparam int                 NREG     = 2**ADDR_W;
    localparam logic [ADDR_W-1:0]  TOP_ADDR = '1;
    localparam logic [NREG-1:0]    TOP_BIT  = {1'b1, {(NREG-1){1'b0}}};
    localparam logic [NREG-1:0]    RO_EFF   = RO_MASK | TOP_BIT;

    typedef enum logic [1:0] {IDLE, WRITE, READ, DISCARD} state_t;

    state_t              state, next_state;
    logic [ADDR_W-1:0]   addr, next_addr;
    logic [7:0]          bank [NREG];
    logic                armed;
    logic                byte_ok;
    logic                cmd_legal;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [ADDR_W-1:0]   rd_addr;
    logic [7:0]          rd_val;
    logic                load_req;
    logic [7:0]          load_val;
    logic                wr_req;
    logic                err_set;
    logic                err_clr;

    assign cmd_addr  = i_Byte[ADDR_W-1:0];
    assign cmd_legal = ((i_Byte[6:0] >> ADDR_W) == 7'd0);
    assign byte_ok   = i_Byte_DV && armed && !i_SPI_CS_n;
    assign rd_addr   = (state == IDLE) ? cmd_addr : addr;
    assign rd_val    = (rd_addr == TOP_ADDR) ? i_Status : bank[rd_addr];

    for (genvar g = 0; g < NREG; g++) begin : g_flat
        assign o_Regs[8*g +: 8] = bank[g];
    end

    // After a reset the rest of the current frame is ignored until chip select is released.
    always_ff @(posedge w_SPI_Clk or negedge i_Rst_L or posedge i_SPI_CS_n) begin
        if (!i_Rst_L) begin
            armed <= 1'b0;
        end else if (i_SPI_CS_n) begin
            armed <= 1'b1;
        end
    end

    // Frame state, address pointer and single-cycle pulses; chip select high aborts the frame.
    always_ff @(posedge w_SPI_Clk or negedge i_Rst_L or posedge i_SPI_CS_n) begin
        if (!i_Rst_L) begin
            state       <= IDLE;
            addr        <= '0;
            o_TX_Load   <= 1'b0;
            o_Wr_Strobe <= 1'b0;
        end else if (i_SPI_CS_n) begin
            state       <= IDLE;
            addr        <= '0;
            o_TX_Load   <= 1'b0;
            o_Wr_Strobe <= 1'b0;
        end else begin
            state       <= next_state;
            addr        <= next_addr;
            o_TX_Load   <= load_req;
            o_Wr_Strobe <= wr_req;
        end
    end

    // Decode each accepted byte into the next state and the actions it triggers.
    always_comb begin
        next_state = state;
        next_addr  = addr;
        load_req   = 1'b0;
        load_val   = 8'h00;
        wr_req     = 1'b0;
        err_set    = 1'b0;
        err_clr    = 1'b0;
        if (byte_ok) begin
            case (state)
                IDLE: begin
                    if (!cmd_legal) begin
                        next_state = DISCARD;
                        err_set    = 1'b1;
                        load_req   = 1'b1;
                        load_val   = 8'h00;
                    end else if (i_Byte[7]) begin
                        next_state = READ;
                        next_addr  = cmd_addr + 1'b1;
                        load_req   = 1'b1;
                        load_val   = rd_val;
                        err_clr    = 1'b1;
                    end else begin
                        next_state = WRITE;
                        next_addr  = cmd_addr;
                        err_clr    = 1'b1;
                    end
                end
                READ: begin
                    load_req  = 1'b1;
                    load_val  = rd_val;
                    next_addr = addr + 1'b1;
                end
                WRITE: begin
                    wr_req    = !RO_EFF[addr];
                    next_addr = addr + 1'b1;
                end
                default: begin
                    next_state = state;
                end
            endcase
        end
    end

    // Register bank, MISO byte, write report and sticky error flag; these survive a frame abort.
    always_ff @(posedge w_SPI_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            for (int i = 0; i < NREG; i++) begin
                bank[i] <= 8'h00;
            end
            o_TX_Byte   <= 8'h00;
            o_Wr_Addr   <= '0;
            o_Wr_Data   <= 8'h00;
            o_Frame_Err <= 1'b0;
        end else begin
            if (load_req) begin
                o_TX_Byte <= load_val;
            end
            if (wr_req) begin
                bank[addr] <= i_Byte;
                o_Wr_Addr  <= addr;
                o_Wr_Data  <= i_Byte;
            end
            if (err_set) begin
                o_Frame_Err <= 1'b1;
            end else if (err_clr) begin
                o_Frame_Err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank: directed scenarios followed by random frames,
// compared against a frame-level model of the register bank.
module tb_spi_reg_bank;

    localparam int          ADDR_W  = 4;
    localparam logic [15:0] RO_MASK = 16'h0002;

    logic          clk = 1'b0;
    logic          rst_l;
    logic          cs_n;
    logic          byte_dv;
    logic [7:0]    byte_in;
    logic [7:0]    status;
    logic          tx_load;
    logic [7:0]    tx_byte;
    logic          wr_strobe;
    logic [3:0]    wr_addr;
    logic [7:0]    wr_data;
    logic [127:0]  regs;
    logic          frame_err;

    spi_reg_bank #(.ADDR_W(ADDR_W), .RO_MASK(RO_MASK)) dut (
        .w_SPI_Clk   (clk),
        .i_Rst_L     (rst_l),
        .i_SPI_CS_n  (cs_n),
        .i_Byte_DV   (byte_dv),
        .i_Byte      (byte_in),
        .i_Status    (status),
        .o_TX_Load   (tx_load),
        .o_TX_Byte   (tx_byte),
        .o_Wr_Strobe (wr_strobe),
        .o_Wr_Addr   (wr_addr),
        .o_Wr_Data   (wr_data),
        .o_Regs      (regs),
        .o_Frame_Err (frame_err)
    );

    // Free-running SPI sample clock.
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Reference model: bank contents plus what is known about the current frame.
    logic [7:0] m_reg [16];
    logic       m_err;
    logic [7:0] m_tx;
    logic [3:0] m_waddr;
    logic [7:0] m_wdata;
    bit         m_armed;
    int         f_pos;
    bit         f_read;
    bit         f_discard;
    int         f_ptr;

    task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] model_flat();
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = m_reg[i];
        return r;
    endfunction

    function automatic logic [7:0] model_read(input int p);
        return (p == 15) ? status : m_reg[p];
    endfunction

    function automatic bit model_ro(input int p);
        return (p == 15) || RO_MASK[p];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_reg[i] = 8'h00;
        m_err = 1'b0; m_tx = 8'h00; m_waddr = 4'h0; m_wdata = 8'h00;
        m_armed = 1'b0; f_pos = 0; f_read = 0; f_discard = 0; f_ptr = 0;
    endtask

    task automatic check_all(input string tag, input bit exp_load, input bit exp_str);
        check_output({tag, "_load"},   128'(tx_load),   128'(exp_load));
        check_output({tag, "_strobe"}, 128'(wr_strobe), 128'(exp_str));
        check_output({tag, "_txbyte"}, 128'(tx_byte),   128'(m_tx));
        check_output({tag, "_waddr"},  128'(wr_addr),   128'(m_waddr));
        check_output({tag, "_wdata"},  128'(wr_data),   128'(m_wdata));
        check_output({tag, "_err"},    128'(frame_err), 128'(m_err));
        check_output({tag, "_regs"},   regs,            model_flat());
    endtask

    // One byte from the receive shifter: predict its effect, pulse DV, check one clock later.
    task automatic apply_stimulus(input string tag, input logic [7:0] b);
        bit exp_load = 0;
        bit exp_str  = 0;
        if (m_armed) begin
            if (f_pos == 0) begin
                if (b[6:4] != 3'b000) begin
                    f_discard = 1; m_err = 1'b1; exp_load = 1; m_tx = 8'h00;
                end else begin
                    m_err = 1'b0; f_ptr = int'(b[3:0]); f_read = b[7];
                    if (f_read) begin
                        exp_load = 1; m_tx = model_read(f_ptr); f_ptr = (f_ptr + 1) % 16;
                    end
                end
            end else if (f_discard) begin
                exp_load = 0;
            end else if (f_read) begin
                exp_load = 1; m_tx = model_read(f_ptr); f_ptr = (f_ptr + 1) % 16;
            end else begin
                if (!model_ro(f_ptr)) begin
                    m_reg[f_ptr] = b; exp_str = 1; m_waddr = 4'(f_ptr); m_wdata = b;
                end
                f_ptr = (f_ptr + 1) % 16;
            end
            f_pos++;
        end
        @(negedge clk);
        byte_in = b;
        byte_dv = 1'b1;
        @(negedge clk);
        byte_dv = 1'b0;
        check_all(tag, exp_load, exp_str);
        @(negedge clk);
        check_output({tag, "_pulse_end"}, 128'({tx_load, wr_strobe}), 128'(0));
        repeat (6) @(negedge clk);
    endtask

    task automatic cs_low();
        @(negedge clk);
        cs_n = 1'b0;
        f_pos = 0; f_read = 0; f_discard = 0;
    endtask

    task automatic cs_high();
        @(negedge clk);
        cs_n = 1'b1;
        m_armed = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        model_reset();
        rst_l = 1'b1; cs_n = 1'b1; byte_dv = 1'b0; byte_in = 8'h00; status = 8'hC3;
        #2 rst_l = 1'b0;
        #4 check_all("reset", 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_l = 1'b1;
        repeat (2) @(negedge clk);
        m_armed = 1'b1;

        $display("[TB] write burst");
        cs_low(); apply_stimulus("wr_cmd", 8'h02); apply_stimulus("wr_a5", 8'hA5); apply_stimulus("wr_5a", 8'h5A); cs_high();

        $display("[TB] read burst");
        cs_low(); apply_stimulus("rd_cmd", 8'h82); apply_stimulus("rd_1", 8'h00); apply_stimulus("rd_2", 8'hFF); cs_high();

        $display("[TB] wrap through status register");
        cs_low(); apply_stimulus("wrap_cmd", 8'h0E); apply_stimulus("wrap_14", 8'h11); apply_stimulus("wrap_15", 8'h22); cs_high();
        status = 8'h6D;
        cs_low(); apply_stimulus("stat_cmd", 8'h8F); apply_stimulus("stat_wrap", 8'h00); cs_high();

        $display("[TB] illegal command");
        cs_low(); apply_stimulus("ill_cmd", 8'h30); apply_stimulus("ill_ff", 8'hFF); cs_high();
        cs_low(); apply_stimulus("ill_clear", 8'h81); cs_high();

        $display("[TB] abort after command");
        cs_low(); apply_stimulus("abort_cmd", 8'h03); cs_high();
        cs_low(); apply_stimulus("abort_rd", 8'h83); cs_high();

        $display("[TB] read-only register");
        cs_low(); apply_stimulus("ro_cmd", 8'h01); apply_stimulus("ro_77", 8'h77); apply_stimulus("ro_88", 8'h88); cs_high();

        $display("[TB] chip select coincident with byte");
        cs_low(); apply_stimulus("co_cmd", 8'h04);
        @(negedge clk);
        byte_in = 8'h99; byte_dv = 1'b1; cs_n = 1'b1;
        @(negedge clk);
        byte_dv = 1'b0; m_armed = 1'b1;
        check_all("co_drop", 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        $display("[TB] reset mid-frame");
        cs_low(); apply_stimulus("rst_cmd", 8'h05);
        #2 rst_l = 1'b0;
        model_reset();
        #1 check_all("rst_mid", 1'b0, 1'b0);
        @(negedge clk);
        rst_l = 1'b1;
        apply_stimulus("rst_ignored", 8'h44);
        cs_high();
        cs_low(); apply_stimulus("rst_rd", 8'h85); apply_stimulus("rst_rd2", 8'h00); cs_high();

        $display("[TB] random frames");
        for (int f = 0; f < 30; f++) begin
            logic [7:0] cmd;
            int nbytes;
            cmd = 8'($urandom);
            if ($urandom_range(0, 7) != 0) cmd[6:4] = 3'b000;
            nbytes = $urandom_range(1, 5);
            status = 8'($urandom);
            cs_low();
            apply_stimulus("rnd_cmd", cmd);
            for (int k = 0; k < nbytes; k++) begin
                status = 8'($urandom);
                apply_stimulus("rnd_data", 8'($urandom));
            end
            cs_high();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
